// File: rtl/vca_pkg.sv
// Shared types and constants for the voice amplifier path.
//   AMPLITUDE_BITS / amplitude : unsigned envelope level produced by adsr
//   SAMPLE_BITS / sample       : signed audio sample
//   gate_env()                 : forces the envelope gain to zero while the note is idle
package vca_pkg;

  localparam int unsigned AMPLITUDE_BITS = 16;
  typedef logic [AMPLITUDE_BITS-1:0] amplitude;

  localparam int unsigned SAMPLE_BITS = 24;
  typedef logic signed [SAMPLE_BITS-1:0] sample;

  function automatic amplitude gate_env(amplitude env, logic active, bit zero_when_idle);
    return (zero_when_idle && !active) ? '0 : env;
  endfunction

endpackage

// File: rtl/vca_scale_stage.sv
// One registered valid/ready pipeline stage computing
//   out = (x * g + 2**(Shift-1)) >>> Shift   (round half up)
// with an exact pass-through when g == UnityGain.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   in_valid_i / in_ready_o  upstream handshake; in_ready_o = !valid_q | out_ready_i
//   in_x_i                   signed operand
//   in_gain_i                unsigned gain
//   out_valid_o / out_ready_i downstream handshake
//   out_x_o                  registered scaled result (held while stalled)
module vca_scale_stage #(
  parameter int unsigned         XBits     = 24,
  parameter int unsigned         GainBits  = 16,
  parameter int unsigned         Shift     = 16,
  parameter logic [GainBits-1:0] UnityGain = '1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [XBits-1:0] in_x_i,
  input  logic [GainBits-1:0]     in_gain_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [XBits-1:0] out_x_o
);

  // Gain is zero-extended to stay non-negative, hence the extra bit.
  localparam int unsigned ProdBits = XBits + GainBits + 1;
  localparam logic [ProdBits-1:0] RoundK = ProdBits'(1) << (Shift - 1);

  logic                    valid_q, valid_d;
  logic signed [XBits-1:0] x_q, x_d;
  logic signed [ProdBits-1:0] prod;
  logic signed [ProdBits-1:0] rounded;
  logic signed [XBits-1:0] scaled;
  logic signed [XBits-1:0] result;
  logic                    adv;

  always_comb begin
    prod    = $signed({{(GainBits + 1){in_x_i[XBits-1]}}, in_x_i}) *
              $signed({{XBits{1'b0}}, 1'b0, in_gain_i});
    rounded = prod + $signed(RoundK);
    scaled  = XBits'(rounded >>> Shift);
    result  = (in_gain_i == UnityGain) ? in_x_i : scaled;

    adv     = !valid_q || out_ready_i;
    valid_d = valid_q;
    x_d     = x_q;
    if (adv) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        x_d = result;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      x_q     <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
    end
  end

  assign in_ready_o  = adv;
  assign out_valid_o = valid_q;
  assign out_x_o     = x_q;

endmodule

// File: rtl/vca.sv
// Envelope-controlled amplifier: scales each oscillator sample by the adsr level and silences
// the output while the envelope is idle. Full-throughput valid/ready pipeline.
//   S1: operand registers (sample, gated envelope gain)
//   S2: vca_scale_stage, envelope scaling (unity bypass at env == all-ones)
//   S3: vca_scale_stage, velocity scaling (only with VCA_VELOCITY_EN)
// Latency is 2 clocks, or 3 with VCA_VELOCITY_EN.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_valid / in_ready      input handshake; in_ready is combinational from out_ready
//   in_sample                signed sample
//   env, env_active          adsr level and activity flag, captured with the sample
//   velocity                 note velocity (VCA_VELOCITY_EN only)
//   out_valid / out_ready    output handshake
//   out_sample               signed scaled sample, stable while stalled
// Macro: VCA_VELOCITY_EN adds the velocity port and the S3 stage.
module vca
  import vca_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS    = vca_pkg::SAMPLE_BITS,
  parameter bit          ZERO_WHEN_IDLE = 1'b1,
  localparam int unsigned VELOCITY_BITS = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [SAMPLE_BITS-1:0] in_sample,
  input  logic [AMPLITUDE_BITS-1:0]     env,
  input  logic                          env_active,
`ifdef VCA_VELOCITY_EN
  input  logic [VELOCITY_BITS-1:0]      velocity,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [SAMPLE_BITS-1:0] out_sample
);

  logic                          s1_valid_q, s1_valid_d;
  logic signed [SAMPLE_BITS-1:0] s1_x_q, s1_x_d;
  amplitude                      s1_gain_q, s1_gain_d;
  logic                          s1_adv;

  logic                          s2_ready;
  logic                          s2_valid;
  logic signed [SAMPLE_BITS-1:0] s2_x;
  logic                          s2_out_ready;

  always_comb begin
    s1_adv     = !s1_valid_q || s2_ready;
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_gain_d  = s1_gain_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_x_d    = in_sample;
        s1_gain_d = gate_env(env, env_active, ZERO_WHEN_IDLE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_gain_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_gain_q  <= s1_gain_d;
    end
  end

  assign in_ready = s1_adv;

  vca_scale_stage #(
    .XBits     (SAMPLE_BITS),
    .GainBits  (AMPLITUDE_BITS),
    .Shift     (AMPLITUDE_BITS),
    .UnityGain ({AMPLITUDE_BITS{1'b1}})
  ) u_env_stage (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (s1_valid_q),
    .in_ready_o  (s2_ready),
    .in_x_i      (s1_x_q),
    .in_gain_i   (s1_gain_q),
    .out_valid_o (s2_valid),
    .out_ready_i (s2_out_ready),
    .out_x_o     (s2_x)
  );

`ifdef VCA_VELOCITY_EN
  // Velocity rides alongside the sample through S1 and S2 so it stays matched to it.
  logic [VELOCITY_BITS-1:0] s1_vel_q, s1_vel_d;
  logic [VELOCITY_BITS-1:0] s2_vel_q, s2_vel_d;
  logic [VELOCITY_BITS:0]   vel_gain;
  logic                     s3_ready;

  always_comb begin
    s1_vel_d = s1_vel_q;
    if (s1_adv && in_valid) begin
      s1_vel_d = velocity;
    end
    // S2 loads exactly when it advances with a valid S1 entry.
    s2_vel_d = s2_vel_q;
    if (s2_ready && s1_valid_q) begin
      s2_vel_d = s1_vel_q;
    end
    // velocity + 1 so that 127 maps to 128 = exact unity after >>> 7
    vel_gain = {1'b0, s2_vel_q} + (VELOCITY_BITS + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vel_q <= '0;
      s2_vel_q <= '0;
    end else begin
      s1_vel_q <= s1_vel_d;
      s2_vel_q <= s2_vel_d;
    end
  end

  assign s2_out_ready = s3_ready;

  vca_scale_stage #(
    .XBits     (SAMPLE_BITS),
    .GainBits  (VELOCITY_BITS + 1),
    .Shift     (VELOCITY_BITS),
    .UnityGain ({1'b1, {VELOCITY_BITS{1'b0}}})
  ) u_vel_stage (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (s2_valid),
    .in_ready_o  (s3_ready),
    .in_x_i      (s2_x),
    .in_gain_i   (vel_gain),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_x_o     (out_sample)
  );
`else
  assign s2_out_ready = out_ready;
  assign out_valid    = s2_valid;
  assign out_sample   = s2_x;
`endif

endmodule

// File: tb/tb_vca.sv
// Scoreboard bench for vca: the driver pushes the hand-computed result of each accepted
// sample; the monitor compares every presented output against the queue head and checks
// in_ready against the number of samples in flight.
module tb_vca;

`ifdef VCA_VELOCITY_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] in_sample;
  logic [15:0]        env;
  logic               env_active;
  logic [6:0]         velocity;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] out_sample;

  vca u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .env        (env),
    .env_active (env_active),
`ifdef VCA_VELOCITY_EN
    .velocity   (velocity),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  longint exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     mon_en = 1'b0;
  int     ready_mode = 0;   // 0: out_ready = ready_force, 1: pattern 1,0,0,1
  logic   ready_force = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out_ready driver
  initial begin
    int k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        out_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end else begin
        out_ready = ready_force;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && mon_en) begin
        check("in_ready", longint'(in_ready),
              longint'(!(exp_q.size() == LAT && !out_ready)));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %0d, expected no output", out_sample);
          end else begin
            check("out_sample", longint'(out_sample), exp_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // Present one sample until accepted; returns at posedge+1 with in_valid still high.
  task automatic send(input longint x, input logic [15:0] e, input logic act,
                      input logic [6:0] vel, input longint exp);
    bit done = 1'b0;
    bit acc;
    in_sample  = x[23:0];
    env        = e;
    env_active = act;
    velocity   = vel;
    in_valid   = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no handshake, expected in_ready within 200 cycles");
    end
  endtask

  // Single sample into an empty pipe with out_ready=1: output appears exactly LAT clocks on.
  task automatic lat_test(input longint x, input logic [15:0] e, input logic act,
                          input logic [6:0] vel, input longint exp);
    send(x, e, act, vel, exp);
    in_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check("latency_early", longint'(out_valid), 0);
    end
    @(negedge clk);
    check("latency_valid", longint'(out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("drain_empty", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sample  = '0;
    env        = '0;
    env_active = 1'b0;
    velocity   = 7'd127;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_sample", longint'(out_sample), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed single samples with latency check
    lat_test(1000, 16'h8000, 1'b1, 7'd127, 500);
    lat_test(-1001, 16'h8000, 1'b1, 7'd127, -500);
    lat_test(-8388608, 16'hFFFF, 1'b1, 7'd127, -8388608);
    lat_test(12345, 16'h0000, 1'b1, 7'd127, 0);
    lat_test(1000, 16'h8000, 1'b0, 7'd127, 0);
`ifdef VCA_VELOCITY_EN
    lat_test(1000, 16'hFFFF, 1'b1, 7'd63, 500);
    lat_test(1000, 16'hFFFF, 1'b1, 7'd127, 1000);
`endif

    // Back-to-back burst at full throughput, rounding boundaries
    send(1, 16'h8000, 1'b1, 7'd127, 1);
    send(-1, 16'h8000, 1'b1, 7'd127, 0);
    send(5000, 16'h0000, 1'b1, 7'd127, 0);
    send(7, 16'hFFFF, 1'b0, 7'd127, 0);
    in_valid = 1'b0;
    drain();

    // Stream of 8 with out_ready toggling 1,0,0,1
    ready_mode = 1;
    send(400, 16'h4000, 1'b1, 7'd127, 100);
    send(-400, 16'h4000, 1'b1, 7'd127, -100);
    send(8388607, 16'hFFFF, 1'b1, 7'd127, 8388607);
    send(2, 16'h8000, 1'b1, 7'd127, 1);
    send(3, 16'h8000, 1'b1, 7'd127, 2);
    send(-3, 16'h8000, 1'b1, 7'd127, -1);
    send(1000, 16'hFFFE, 1'b1, 7'd127, 1000);
    send(-8388608, 16'h0001, 1'b1, 7'd127, -128);
    in_valid = 1'b0;
    drain();
    ready_mode  = 0;
    ready_force = 1'b1;
    @(posedge clk);
    #2;

    // Reset with two samples in flight
    ready_force = 1'b0;
    @(posedge clk);
    #2;
    send(111, 16'h8000, 1'b1, 7'd127, 56);
    send(222, 16'h8000, 1'b1, 7'd127, 111);
    in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midreset_out_valid", longint'(out_valid), 0);
    check("midreset_out_sample", longint'(out_sample), 0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    ready_force = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    lat_test(1, 16'h8000, 1'b1, 7'd127, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
